// File: rtl/k12a_spi_multi_if.sv
// CPU-side register bus of the multi-channel SPI master: strobes, address and both data directions.
interface k12a_spi_multi_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  io_store;
    logic                  io_load;
    logic [1:0]            io_addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output io_store, io_load, io_addr, wdata, input rdata);
    modport slave  (input io_store, io_load, io_addr, wdata, output rdata);
endinterface

// File: rtl/k12a_spi_multi.sv
// Multi-channel SPI master: one frame engine whose SCK/MOSI/MISO are routed to the channel chosen in CTRL.CH.
//
// state   | meaning
// S_IDLE  | waiting for a DATA write; sck at CPOL, mosi low
// S_SHIFT | frame in flight; divider paces 2*DATA_WIDTH SCK edges
// S_DONE  | one cycle: RX valid, DONE set, wake pulse if IE
module k12a_spi_multi #(
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                cpu_clock,
    input  logic                reset,
    k12a_spi_multi_if.slave     bus,
    output logic [CHANNELS-1:0] sck,
    output logic [CHANNELS-1:0] mosi,
    input  logic [CHANNELS-1:0] miso,
    output logic                busy,
    output logic                wake
);
    localparam int EW = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [7:0]            ctrl_q, ctrl_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [DIV_WIDTH-1:0]  divcnt_q, divcnt_d;
    logic [EW-1:0]         edgecnt_q, edgecnt_d;
    logic                  phase_q, phase_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rxsh_q, rxsh_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic                  done_q, done_d;
    logic                  ovr_q, ovr_d;

    logic                  cpol, cpha, lsbf, ie;
    logic [3:0]            ch;
    logic                  ch_valid;
    logic                  sel_miso;
    logic                  tick;
    logic                  sample_now;
    logic [EW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic                  tx_bit;
    logic [DATA_WIDTH-1:0] rxsh_nx;
    logic                  wr_data, wr_ctrl, wr_div, rd_status;

    assign cpol      = ctrl_q[0];
    assign cpha      = ctrl_q[1];
    assign lsbf      = ctrl_q[2];
    assign ie        = ctrl_q[3];
    assign ch        = ctrl_q[7:4];
    assign ch_valid  = ({1'b0, ch} < 5'(CHANNELS));

    assign busy      = (state_q != S_IDLE);
    assign wake      = (state_q == S_DONE) && ie;

    assign wr_data   = bus.io_store && (bus.io_addr == 2'd0);
    assign wr_ctrl   = bus.io_store && (bus.io_addr == 2'd1);
    assign wr_div    = bus.io_store && (bus.io_addr == 2'd2);
    assign rd_status = bus.io_load  && (bus.io_addr == 2'd3);

    assign tick       = (divcnt_q == div_q);
    // Odd-numbered edges (edgecnt even before the toggle) are leading edges.
    assign sample_now = tick && (~edgecnt_q[0] ^ cpha);

    // Bit being presented: CPHA=0 advances on trailing edges, CPHA=1 on leading edges.
    always_comb begin
        bit_idx = edgecnt_q >> 1;
        if (cpha) begin
            bit_idx = (edgecnt_q == '0) ? '0 : ((edgecnt_q - EW'(1)) >> 1);
        end
        tx_sh  = lsbf ? (tx_q >> bit_idx) : (tx_q << bit_idx);
        tx_bit = lsbf ? tx_sh[0] : tx_sh[DATA_WIDTH-1];
    end

    always_comb begin
        sel_miso = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_valid && (ch == 4'(i))) begin
                sel_miso = miso[i];
            end
        end
        rxsh_nx = lsbf ? {sel_miso, rxsh_q[DATA_WIDTH-1:1]} : {rxsh_q[DATA_WIDTH-2:0], sel_miso};
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            sck[i]  = cpol;
            mosi[i] = 1'b0;
            if ((state_q == S_SHIFT) && ch_valid && (ch == 4'(i))) begin
                sck[i]  = cpol ^ phase_q;
                mosi[i] = tx_bit;
            end
        end
    end

    always_comb begin
        case (bus.io_addr)
            2'd0:    bus.rdata = rx_q;
            2'd1:    bus.rdata = DATA_WIDTH'(ctrl_q);
            2'd2:    bus.rdata = DATA_WIDTH'(div_q);
            default: bus.rdata = DATA_WIDTH'({ovr_q, done_q, busy});
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        div_d     = div_q;
        divcnt_d  = divcnt_q;
        edgecnt_d = edgecnt_q;
        phase_d   = phase_q;
        tx_d      = tx_q;
        rxsh_d    = rxsh_q;
        rx_d      = rx_q;
        done_d    = done_q;
        ovr_d     = ovr_q;

        if (rd_status) begin
            done_d = 1'b0;
            ovr_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (wr_ctrl) begin
                    ctrl_d = bus.wdata[7:0];
                end
                if (wr_div) begin
                    div_d = DIV_WIDTH'(bus.wdata);
                end
                if (wr_data) begin
                    state_d   = S_SHIFT;
                    tx_d      = bus.wdata;
                    rxsh_d    = '0;
                    divcnt_d  = '0;
                    edgecnt_d = '0;
                    phase_d   = 1'b0;
                end
            end
            S_SHIFT: begin
                if (wr_data) begin
                    ovr_d = 1'b1;
                end
                if (tick) begin
                    divcnt_d  = '0;
                    edgecnt_d = edgecnt_q + EW'(1);
                    phase_d   = ~phase_q;
                    if (sample_now) begin
                        rxsh_d = rxsh_nx;
                    end
                    if (edgecnt_q == LAST_EDGE) begin
                        state_d = S_DONE;
                        rx_d    = sample_now ? rxsh_nx : rxsh_q;
                        done_d  = 1'b1;
                    end
                end else begin
                    divcnt_d = divcnt_q + DIV_WIDTH'(1);
                end
            end
            S_DONE: begin
                if (wr_data) begin
                    ovr_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            div_q     <= '0;
            divcnt_q  <= '0;
            edgecnt_q <= '0;
            phase_q   <= 1'b0;
            tx_q      <= '0;
            rxsh_q    <= '0;
            rx_q      <= '0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            div_q     <= div_d;
            divcnt_q  <= divcnt_d;
            edgecnt_q <= edgecnt_d;
            phase_q   <= phase_d;
            tx_q      <= tx_d;
            rxsh_q    <= rxsh_d;
            rx_q      <= rx_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
        end
    end
endmodule

// File: tb/tb_k12a_spi_multi.sv
// Scoreboard bench for k12a_spi_multi: frames are modelled at the protocol level and checked by a wire-level monitor.
module tb_k12a_spi_multi;
    localparam int CH = 2;
    localparam int W  = 8;
    localparam int DW = 8;

    logic          cpu_clock = 1'b0;
    logic          reset     = 1'b1;
    logic [CH-1:0] sck, mosi, miso;
    logic          busy, wake;

    always #5 cpu_clock = ~cpu_clock;

    k12a_spi_multi_if #(.DATA_WIDTH(W)) bus ();

    k12a_spi_multi #(.CHANNELS(CH), .DATA_WIDTH(W), .DIV_WIDTH(DW)) dut (
        .cpu_clock (cpu_clock),
        .reset     (reset),
        .bus       (bus),
        .sck       (sck),
        .mosi      (mosi),
        .miso      (miso),
        .busy      (busy),
        .wake      (wake)
    );

    typedef struct {
        logic [W-1:0] tx;
        logic [W-1:0] rx;
        logic [W-1:0] miso_word;
        bit           loop;
        int           ch;
        bit           cpol, cpha, lsbf;
        int           div;
        int           busy_cycles;
        int           edges;
        int           wake;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    bit   loop_mode     = 1'b0;
    logic slave_bit     = 1'b0;
    bit   abort_pending = 1'b0;

    assign miso = loop_mode ? mosi : {CH{slave_bit}};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic bit_at(input logic [W-1:0] w, input int k, input bit lsbf);
        return lsbf ? w[k] : w[W-1-k];
    endfunction

    // Protocol-level expectation of one frame.
    function automatic exp_t model(input logic [W-1:0] tx, input logic [7:0] ctrl, input int div,
                                   input logic [W-1:0] mw, input bit loop);
        exp_t e;
        bit   valid;
        e.tx          = tx;
        e.miso_word   = mw;
        e.loop        = loop;
        e.cpol        = ctrl[0];
        e.cpha        = ctrl[1];
        e.lsbf        = ctrl[2];
        e.ch          = int'(ctrl[7:4]);
        e.div         = div;
        valid         = (e.ch < CH);
        e.rx          = valid ? (loop ? tx : mw) : '0;
        e.busy_cycles = 2 * W * (div + 1) + 1;
        e.edges       = valid ? 2 * W : 0;
        e.wake        = ctrl[3] ? 1 : 0;
        return e;
    endfunction

    // Monitor: tracks wire activity per frame and scores it when busy drops.
    exp_t          cur;
    int            busy_cnt, sel_edges, oth_edges, wake_cnt, unsel_bad, nbits;
    int            cyc, last_edge, first_off, min_sp, max_sp;
    logic [W-1:0]  mosi_word;
    logic          prev_busy = 1'b0;
    logic [CH-1:0] prev_sck  = '0;
    logic [CH-1:0] prev_mosi = '0;

    always @(negedge cpu_clock) begin
        exp_t e;
        if (busy === 1'b1 && prev_busy !== 1'b1) begin
            if (exp_q.size() > 0) cur = exp_q[0];
            else begin
                cur    = '{default: 0};
                cur.ch = 15;
            end
            busy_cnt = 0; sel_edges = 0; oth_edges = 0; wake_cnt = 0; unsel_bad = 0; nbits = 0;
            cyc = 0; last_edge = 0; first_off = -1; min_sp = 1 << 30; max_sp = 0; mosi_word = '0;
            loop_mode = cur.loop;
            slave_bit = bit_at(cur.miso_word, 0, cur.lsbf);
        end
        if (busy === 1'b1) begin
            busy_cnt++;
            for (int i = 0; i < CH; i++) begin
                if (sck[i] !== prev_sck[i]) begin
                    if (i == cur.ch) begin
                        sel_edges++;
                        if (first_off < 0) first_off = cyc;
                        else begin
                            if (cyc - last_edge < min_sp) min_sp = cyc - last_edge;
                            if (cyc - last_edge > max_sp) max_sp = cyc - last_edge;
                        end
                        last_edge = cyc;
                        if ((prev_sck[i] == cur.cpol) ^ cur.cpha) begin
                            if (nbits < W) begin
                                if (cur.lsbf) mosi_word[nbits] = prev_mosi[i];
                                else          mosi_word[W-1-nbits] = prev_mosi[i];
                            end
                            nbits++;
                            if (nbits < W) slave_bit = bit_at(cur.miso_word, nbits, cur.lsbf);
                        end
                    end else begin
                        oth_edges++;
                    end
                end
                if (i != cur.ch && mosi[i] !== 1'b0) unsel_bad++;
            end
            if (wake === 1'b1) wake_cnt++;
            cyc++;
        end
        if (busy !== 1'b1 && prev_busy === 1'b1) begin
            if (abort_pending) begin
                abort_pending = 1'b0;
            end else if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame: got a frame, expected none");
            end else begin
                e = exp_q.pop_front();
                check("busy_cycles", busy_cnt, e.busy_cycles);
                check("sel_edges", sel_edges, e.edges);
                check("other_edges", oth_edges, 0);
                check("mosi_bits", nbits, e.edges / 2);
                if (nbits == W) check("mosi_word", mosi_word, e.tx);
                check("rx_data", bus.rdata, e.rx);
                check("wake_count", wake_cnt, e.wake);
                check("unsel_mosi", unsel_bad, 0);
                check("sck_idle", sck, {CH{e.cpol}});
                if (first_off >= 0) check("first_edge", first_off, e.div + 1);
                if (sel_edges >= 2) begin
                    check("edge_min_spacing", min_sp, e.div + 1);
                    check("edge_max_spacing", max_sp, e.div + 1);
                end
            end
            loop_mode = 1'b0;
            slave_bit = 1'b0;
        end
        prev_busy = busy;
        prev_sck  = sck;
        prev_mosi = mosi;
    end

    task automatic bus_write(input logic [1:0] a, input logic [W-1:0] d);
        @(posedge cpu_clock); #1;
        bus.io_addr  = a;
        bus.wdata    = d;
        bus.io_store = 1'b1;
        @(posedge cpu_clock); #1;
        bus.io_store = 1'b0;
        bus.io_addr  = 2'd0;
    endtask

    task automatic bus_read_check(input logic [1:0] a, input logic [W-1:0] e, input string name);
        @(posedge cpu_clock); #1;
        bus.io_addr = a;
        bus.io_load = 1'b1;
        #1;
        check(name, bus.rdata, e);
        @(posedge cpu_clock); #1;
        bus.io_load = 1'b0;
        bus.io_addr = 2'd0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy === 1'b1 && n < limit) begin
            @(posedge cpu_clock); #1;
            n++;
        end
        check("frame_finishes", busy, 1'b0);
        repeat (2) @(posedge cpu_clock);
    endtask

    task automatic run_frame(input logic [W-1:0] tx, input logic [7:0] ctrl, input int div,
                             input logic [W-1:0] mw, input bit loop, input bit ovr);
        bus_write(2'd1, ctrl);
        bus_write(2'd2, W'(div));
        exp_q.push_back(model(tx, ctrl, div, mw, loop));
        bus_write(2'd0, tx);
        if (ovr) begin
            repeat (3) @(posedge cpu_clock);
            bus_write(2'd0, 8'h77);
            bus_write(2'd1, 8'h01);
            bus_write(2'd2, 8'h00);
            bus_read_check(2'd1, ctrl, "ctrl_locked");
            bus_read_check(2'd2, W'(div), "div_locked");
        end
        wait_idle(2 * W * (div + 1) + 20);
        bus_read_check(2'd3, ovr ? 8'h06 : 8'h02, "status_done");
        bus_read_check(2'd3, 8'h00, "status_clear");
    endtask

    initial begin
        bus.io_store = 1'b0;
        bus.io_load  = 1'b0;
        bus.io_addr  = 2'd0;
        bus.wdata    = '0;
        repeat (3) @(posedge cpu_clock);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_wake", wake, 1'b0);
        check("rst_sck", sck, '0);
        check("rst_mosi", mosi, '0);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) bus_read_check(2'(a), 8'h00, "rst_reg");

        run_frame(8'hA5, 8'h00, 0, 8'h00, 1'b1, 1'b0);
        run_frame(8'h3C, 8'h1B, 3, 8'hFF, 1'b0, 1'b0);
        run_frame(8'h01, 8'h04, 0, 8'h00, 1'b0, 1'b0);
        run_frame(8'h55, 8'h00, 3, 8'hC3, 1'b0, 1'b1);
        run_frame(8'hFF, 8'hF0, 0, 8'hFF, 1'b0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            logic [7:0] c;
            logic [3:0] chs;
            chs = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, CH));
            c   = {chs, 4'($urandom_range(0, 15))};
            run_frame(8'($urandom), c, $urandom_range(0, 3), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end

        bus_write(2'd1, 8'h00);
        bus_write(2'd2, 8'h00);
        abort_pending = 1'b1;
        bus_write(2'd0, 8'h5A);
        repeat (4) @(posedge cpu_clock);
        #1 reset = 1'b1;
        @(posedge cpu_clock); #1;
        reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_sck", sck, '0);
        check("abort_mosi", mosi, '0);
        bus_read_check(2'd3, 8'h00, "abort_status");
        bus_read_check(2'd0, 8'h00, "abort_rx");
        repeat (3) @(posedge cpu_clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
